spi_bus_responder: RTL

Memory-mapped SPI master controller that acts as a responder on the MIPS data bus, alongside the byte-lane data RAM. The CPU initiates bus cycles (chip select, byte-lane write strobes, read enable, word address, bidirectional data). The block decodes those cycles into four 32-bit registers and runs one 8-bit SPI mode-0 transfer per write to TXDATA.

---
 rtl/spi_bus_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_bus_responder.sv
// Data-bus responder wrapping a single-byte SPI mode-0 master (CTRL/STATUS/TXDATA/RXDATA).
// Define SPI_IRQ_EN to implement CTRL.IRQ_EN and the registered completion interrupt.
module spi_bus_responder #(
    parameter int                   DIV_WIDTH = 8,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [3:0]  we,
    input  logic        oe,
    input  logic [1:0]  address,
    inout  wire  [31:0] data,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        ss_n,
    output logic        irq
);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_TXDATA = 2'd2;
    localparam logic [1:0] A_RXDATA = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] xdiv_q, xdiv_d;
    logic [DIV_WIDTH-1:0] hp_cnt_q, hp_cnt_d;
    logic [3:0]           half_q, half_d;
    logic [7:0]           tx_sh_q, tx_sh_d;
    logic [7:0]           rx_sh_q, rx_sh_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 irq_en_q, irq_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 ss_n_q, ss_n_d;
    logic                 irq_q, irq_d;

    logic                 rd_en, rd_rx, wr_div, wr_tx, hp_end;
    logic [31:0]          rd_data;

    // A bus cycle is qualified by cs: strobed lanes write on the clock edge, while a
    // read (oe with no strobes) is answered combinationally and has its side effect on the edge.
    assign rd_en  = cs & oe & ~|we;
    assign rd_rx  = rd_en & (address == A_RXDATA);
    assign wr_div = cs & we[0] & (address == A_CTRL);
    assign wr_tx  = cs & we[0] & (address == A_TXDATA);
    assign hp_end = (hp_cnt_q == xdiv_q);

    always_comb begin
        rd_data = '0;
        case (address)
            A_CTRL: begin
                rd_data[DIV_WIDTH-1:0] = div_q;
                rd_data[8]             = irq_en_q;
            end
            A_STATUS: rd_data[2:0] = {ovr_q, done_q, busy_q};
            A_RXDATA: rd_data[7:0] = rx_data_q;
            default:  rd_data      = '0;
        endcase
    end

    assign data = rd_en ? rd_data : 32'bz;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        xdiv_d    = xdiv_q;
        hp_cnt_d  = hp_cnt_q;
        half_d    = half_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        irq_en_d  = irq_en_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_n_d    = ss_n_q;
        irq_d     = 1'b0;

        if (wr_div) div_d = data[DIV_WIDTH-1:0];
`ifdef SPI_IRQ_EN
        if (cs && we[1] && address == A_CTRL) irq_en_d = data[8];
        irq_d = irq_en_q & done_q;
`else
        irq_en_d = 1'b0;
`endif

        // Read clear is applied first so a DONE set on the same edge wins.
        if (rd_rx) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (wr_tx && busy_q) ovr_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (wr_tx) begin
                    state_d  = ST_LEAD;
                    tx_sh_d  = data[7:0];
                    mosi_d   = data[7];
                    ss_n_d   = 1'b0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    hp_cnt_d = '0;
                    xdiv_d   = div_q;
                end
            end
            ST_LEAD: begin
                if (hp_end) begin
                    hp_cnt_d = '0;
                    half_d   = '0;
                    sclk_d   = 1'b1;
                    rx_sh_d  = {rx_sh_q[6:0], miso};
                    state_d  = ST_SHIFT;
                end else begin
                    hp_cnt_d = hp_cnt_q + DIV_WIDTH'(1);
                end
            end
            ST_SHIFT: begin
                if (hp_end) begin
                    hp_cnt_d = '0;
                    if (half_q == 4'd15) begin
                        state_d = ST_TRAIL;
                    end else begin
                        half_d = half_q + 4'd1;
                        if (sclk_q) begin
                            sclk_d  = 1'b0;
                            tx_sh_d = {tx_sh_q[6:0], 1'b0};
                            mosi_d  = tx_sh_q[6];
                        end else begin
                            sclk_d  = 1'b1;
                            rx_sh_d = {rx_sh_q[6:0], miso};
                        end
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + DIV_WIDTH'(1);
                end
            end
            ST_TRAIL: begin
                if (hp_end) begin
                    hp_cnt_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    hp_cnt_d = hp_cnt_q + DIV_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                ss_n_d    = 1'b1;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                rx_data_d = rx_sh_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_q     <= DIV_RESET;
            xdiv_q    <= '0;
            hp_cnt_q  <= '0;
            half_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            irq_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            xdiv_q    <= xdiv_d;
            hp_cnt_q  <= hp_cnt_d;
            half_q    <= half_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            irq_en_q  <= irq_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
            irq_q     <= irq_d;
        end
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign ss_n = ss_n_q;
    assign irq  = irq_q;

endmodule
